// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and constants for the core memory bus arbiter:
// FSM state encoding, round-robin pointer, one-hot grant constants and the grant picker.
package core_mem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    typedef enum logic {
        RR_M1,
        RR_M2
    } rr_ptr_t;

    localparam logic [2:0] ARB_GNT_NONE = 3'b000;
    localparam logic [2:0] ARB_GNT_M0   = 3'b001;
    localparam logic [2:0] ARB_GNT_M1   = 3'b010;
    localparam logic [2:0] ARB_GNT_M2   = 3'b100;

    // M0 always wins; between the core masters the rr_ptr master goes first.
    function automatic logic [2:0] arb_pick(input logic [2:0] req, input rr_ptr_t rr);
        logic [2:0] pick;
        pick = ARB_GNT_NONE;
        if (req[0]) begin
            pick = ARB_GNT_M0;
        end else if (rr == RR_M1) begin
            if (req[1])      pick = ARB_GNT_M1;
            else if (req[2]) pick = ARB_GNT_M2;
        end else begin
            if (req[2])      pick = ARB_GNT_M2;
            else if (req[1]) pick = ARB_GNT_M1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/core_mem_arbiter.sv
// Three-master arbiter for the core's single memory/peripheral bus port (M0 debug, M1 LSU, M2 fetch).
// Optional BUSY timeout abort is enabled by defining CORE_ARB_TIMEOUT_EN.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic              m2_req_i,
    input  logic [ADDR_W-1:0] m2_addr_i,
    output logic              m0_ack_o,
    output logic              m1_ack_o,
    output logic              m2_ack_o,
    output logic [DATA_W-1:0] m_rdata_o,
    output logic              s_req_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic [DATA_W-1:0] s_rdata_i,
    input  logic              s_ack_i,
    output logic [2:0]        grant_o,
    output logic              hold_flag_o,
    output logic              err_o
);

    arb_state_t state, state_next;
    rr_ptr_t    rr_ptr, rr_next;
    logic [2:0] grant, grant_next;
    logic [2:0] req_vec;
    logic       req_g;
    logic       ack_ok;
    logic       tmo_hit;
    logic       done;

    assign req_vec = {m2_req_i, m1_req_i, m0_req_i};
    // grant is only non-zero in BUSY, so req_g also implies BUSY
    assign req_g   = |(req_vec & grant);
    assign ack_ok  = (state == ARB_BUSY) & req_g & s_ack_i;
    assign done    = ack_ok | tmo_hit;

`ifdef CORE_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            tmo_cnt <= '0;
        end else if (!s_ack_i) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // counter lags the BUSY cycle number by one, so compare against TIMEOUT_CYC-1
    assign tmo_hit = (state == ARB_BUSY) & req_g & ~s_ack_i
                   & (tmo_cnt == 8'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^8'(TIMEOUT_CYC);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= RR_M1;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            rr_ptr <= rr_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        rr_next    = rr_ptr;
        unique case (state)
            ARB_IDLE: begin
                if (|req_vec) begin
                    state_next = ARB_BUSY;
                    grant_next = arb_pick(req_vec, rr_ptr);
                end
            end
            ARB_BUSY: begin
                if (done || !req_g) begin
                    state_next = ARB_IDLE;
                    grant_next = '0;
                    if (done && !grant[0]) begin
                        rr_next = grant[1] ? RR_M2 : RR_M1;
                    end
                end
            end
            default: begin
                state_next = ARB_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_comb begin
        s_req_o   = req_g;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        if (grant[0]) begin
            s_we_o    = m0_we_i;
            s_addr_o  = m0_addr_i;
            s_wdata_o = m0_wdata_i;
        end else if (grant[1]) begin
            s_we_o    = m1_we_i;
            s_addr_o  = m1_addr_i;
            s_wdata_o = m1_wdata_i;
        end else if (grant[2]) begin
            s_addr_o  = m2_addr_i;
        end
        m0_ack_o  = grant[0] & done;
        m1_ack_o  = grant[1] & done;
        m2_ack_o  = grant[2] & done;
        m_rdata_o = ack_ok ? s_rdata_i : '0;
        err_o     = tmo_hit;
    end

    assign grant_o     = grant;
    assign hold_flag_o = (m1_req_i & ~m1_ack_o) | (m2_req_i & ~m2_ack_o);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model. Honours CORE_ARB_TIMEOUT_EN (uses TIMEOUT_CYC=4 when defined).
`timescale 1ns/1ps
module tb_core_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef CORE_ARB_TIMEOUT_EN
    localparam int unsigned TMO    = 4;
    localparam bit          TMO_EN = 1'b1;
`else
    localparam int unsigned TMO    = 255;
    localparam bit          TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [2:0]    req = '0;
    logic [1:0]    we = '0;
    logic [AW-1:0] addr [3];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] s_rdata = '0;
    logic          s_ack = 1'b0;

    logic          m0_ack, m1_ack, m2_ack;
    logic [2:0]    ack;
    logic [DW-1:0] m_rdata;
    logic          s_req, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [2:0]    grant;
    logic          hold, err;

    int checks = 0;
    int errors = 0;

    assign ack = {m2_ack, m1_ack, m0_ack};

    core_mem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req_i    (req[0]),
        .m0_we_i     (we[0]),
        .m0_addr_i   (addr[0]),
        .m0_wdata_i  (wdata[0]),
        .m1_req_i    (req[1]),
        .m1_we_i     (we[1]),
        .m1_addr_i   (addr[1]),
        .m1_wdata_i  (wdata[1]),
        .m2_req_i    (req[2]),
        .m2_addr_i   (addr[2]),
        .m0_ack_o    (m0_ack),
        .m1_ack_o    (m1_ack),
        .m2_ack_o    (m2_ack),
        .m_rdata_o   (m_rdata),
        .s_req_o     (s_req),
        .s_we_o      (s_we),
        .s_addr_o    (s_addr),
        .s_wdata_o   (s_wdata),
        .s_rdata_i   (s_rdata),
        .s_ack_i     (s_ack),
        .grant_o     (grant),
        .hold_flag_o (hold),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0; we = '0; s_ack = 1'b0; s_rdata = '0;
        for (int i = 0; i < 3; i++) addr[i] = '0;
        for (int i = 0; i < 2; i++) wdata[i] = '0;
        @(negedge clk);
        checks++;
        if ({grant, s_req, s_we, ack, err, hold} !== 10'b0 || s_addr !== '0 || s_wdata !== '0 || m_rdata !== '0)
            begin errors++; $display("FAIL reset_outputs: grant=%b s_req=%b s_we=%b ack=%b err=%b hold=%b addr=%h wdata=%h rdata=%h required all zero",
                grant, s_req, s_we, ack, err, hold, s_addr, s_wdata, m_rdata); end
        req[1] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (grant !== 3'b000) begin errors++; $display("FAIL reset_no_grant: grant=%b required 000", grant); end
        req[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        req[2] = 1'b1; addr[2] = 32'h0000_0100; s_ack = 1'b1; s_rdata = 32'h0000_0013;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000 || ack !== 3'b000) begin errors++; $display("FAIL fetch_cycle0: grant=%b ack=%b required 000/000", grant, ack); end
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 3'b100 || ack !== 3'b100 || s_req !== 1'b1 || s_addr !== 32'h0000_0100 || m_rdata !== 32'h0000_0013)
            begin errors++; $display("FAIL fetch_cycle1: grant=%b ack=%b s_req=%b addr=%h rdata=%h required 100/100/1/00000100/00000013",
                grant, ack, s_req, s_addr, m_rdata); end
        tick();
        req[2] = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000 || ack !== 3'b000) begin errors++; $display("FAIL fetch_cycle2: grant=%b ack=%b required 000/000", grant, ack); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g;
        req[1] = 1'b1; req[2] = 1'b1; we[1] = 1'b0; s_ack = 1'b1; s_rdata = 32'hCAFE_0001;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0) ? 3'b000 : ((i == 3) ? 3'b100 : 3'b010);
            @(negedge clk);
            checks++;
            if (grant !== exp_g || ack !== exp_g || hold !== 1'b1)
                begin errors++; $display("FAIL rr_step%0d: grant=%b ack=%b hold=%b required %b/%b/1", i, grant, ack, hold, exp_g, exp_g); end
            tick();
        end
        req = '0; s_ack = 1'b0;
        tick();
    endtask

    task automatic test_m0_priority();
        req = 3'b111; we[0] = 1'b1; addr[0] = 32'h1000_0000; wdata[0] = 32'hDEAD_BEEF;
        addr[1] = 32'h0000_0080; addr[2] = 32'h0000_0200; s_ack = 1'b1; s_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000) begin errors++; $display("FAIL m0_idle: grant=%b required 000", grant); end
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 3'b001 || s_we !== 1'b1 || s_wdata !== 32'hDEAD_BEEF || s_addr !== 32'h1000_0000 || ack !== 3'b001)
            begin errors++; $display("FAIL m0_write: grant=%b we=%b wdata=%h addr=%h ack=%b required 001/1/deadbeef/10000000/001",
                grant, s_we, s_wdata, s_addr, ack); end
        tick();
        req[0] = 1'b0; we[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000) begin errors++; $display("FAIL m0_bubble: grant=%b required 000", grant); end
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 3'b100 || s_addr !== 32'h0000_0200 || s_we !== 1'b0 || ack !== 3'b100 || m_rdata !== 32'h1234_5678)
            begin errors++; $display("FAIL m0_then_rr: grant=%b addr=%h we=%b ack=%b rdata=%h required 100/00000200/0/100/12345678",
                grant, s_addr, s_we, ack, m_rdata); end
        tick();
        req = '0; s_ack = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        int unsigned stall;
        stall = (TMO > 6) ? 5 : TMO - 1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h2000_0040; wdata[1] = 32'h5A5A_0001; s_ack = 1'b0;
        tick();
        for (int unsigned c = 1; c <= stall; c++) begin
            @(negedge clk);
            checks++;
            if (grant !== 3'b010 || s_req !== 1'b1 || s_addr !== 32'h2000_0040 || s_we !== 1'b1 ||
                s_wdata !== 32'h5A5A_0001 || ack !== 3'b000 || err !== 1'b0)
                begin errors++; $display("FAIL stall_c%0d: grant=%b s_req=%b addr=%h we=%b wdata=%h ack=%b err=%b required 010/1/20000040/1/5a5a0001/000/0",
                    c, grant, s_req, s_addr, s_we, s_wdata, ack, err); end
            tick();
        end
        s_ack = 1'b1; s_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        checks++;
        if (ack !== 3'b010 || err !== 1'b0)
            begin errors++; $display("FAIL stall_ack: ack=%b err=%b required 010/0", ack, err); end
        tick();
        req = '0; we = '0; s_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000) begin errors++; $display("FAIL stall_release: grant=%b required 000", grant); end
        tick();
    endtask

    task automatic test_timeout();
        req[2] = 1'b1; addr[2] = 32'h0000_0300; s_ack = 1'b0; s_rdata = 32'hFFFF_FFFF;
        tick();
`ifdef CORE_ARB_TIMEOUT_EN
        for (int unsigned c = 1; c <= TMO; c++) begin
            @(negedge clk);
            checks++;
            if (c < TMO) begin
                if (grant !== 3'b100 || ack !== 3'b000 || err !== 1'b0)
                    begin errors++; $display("FAIL tmo_wait_c%0d: grant=%b ack=%b err=%b required 100/000/0", c, grant, ack, err); end
            end else begin
                if (ack !== 3'b100 || err !== 1'b1 || m_rdata !== '0)
                    begin errors++; $display("FAIL tmo_fire: ack=%b err=%b rdata=%h required 100/1/00000000", ack, err, m_rdata); end
            end
            tick();
        end
        req[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000 || err !== 1'b0) begin errors++; $display("FAIL tmo_idle: grant=%b err=%b required 000/0", grant, err); end
        tick();
`else
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            checks++;
            if (grant !== 3'b100 || ack !== 3'b000 || err !== 1'b0)
                begin errors++; $display("FAIL notmo_c%0d: grant=%b ack=%b err=%b required 100/000/0", c, grant, ack, err); end
            tick();
        end
        s_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 3'b100 || err !== 1'b0 || m_rdata !== 32'hFFFF_FFFF)
            begin errors++; $display("FAIL notmo_ack: ack=%b err=%b rdata=%h required 100/0/ffffffff", ack, err, m_rdata); end
        tick();
        req = '0; s_ack = 1'b0;
        tick();
`endif
    endtask

    task automatic test_abort_reset();
        req[2] = 1'b1; addr[2] = 32'h0000_0400; s_ack = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 3'b100 || s_req !== 1'b1) begin errors++; $display("FAIL rst_pre: grant=%b s_req=%b required 100/1", grant, s_req); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (grant !== 3'b000 || s_req !== 1'b0 || ack !== 3'b000)
            begin errors++; $display("FAIL rst_async: grant=%b s_req=%b ack=%b required 000/0/000", grant, s_req, ack); end
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        tick();
        req[1] = 1'b1; addr[1] = 32'h0000_0500; we[1] = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 3'b010 || s_req !== 1'b1) begin errors++; $display("FAIL abort_pre: grant=%b s_req=%b required 010/1", grant, s_req); end
        tick();
        req[1] = 1'b0;
        #1;
        checks++;
        if (s_req !== 1'b0 || ack !== 3'b000) begin errors++; $display("FAIL abort_drop: s_req=%b ack=%b required 0/000", s_req, ack); end
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 3'b000) begin errors++; $display("FAIL abort_idle: grant=%b required 000", grant); end
        tick();
        req[1] = 1'b1; req[2] = 1'b1; s_ack = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 3'b010 || ack !== 3'b010) begin errors++; $display("FAIL abort_next: grant=%b ack=%b required 010/010", grant, ack); end
        tick();
        req = '0; s_ack = 1'b0;
        tick();
    endtask

    // Transaction-level reference: owner (-1 = none), preferred core master, BUSY age.
    task automatic test_random();
        int            owner, pref, bcnt;
        logic [2:0]    e_grant, e_ack;
        logic          e_sreq, e_we, e_err, e_hold, fin_ok, fin_tmo;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_rdata;
        @(negedge clk);
        req = '0; s_ack = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        owner = -1; pref = 1; bcnt = 0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && $urandom_range(0, 9) < 3) begin
                    req[i]  = 1'b1;
                    addr[i] = $urandom;
                    if (i < 2) begin
                        we[i]    = 1'($urandom_range(0, 1));
                        wdata[i] = $urandom;
                    end
                end
            end
            s_ack   = ($urandom_range(0, 9) < 4);
            s_rdata = $urandom;
            @(negedge clk);
            e_grant = '0; e_ack = '0; e_sreq = 1'b0; e_we = 1'b0; e_err = 1'b0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
            if (owner >= 0) begin
                e_grant[owner] = 1'b1;
                e_sreq = req[owner];
                e_addr = addr[owner];
                if (owner < 2) begin
                    e_we    = we[owner];
                    e_wdata = wdata[owner];
                end
                fin_ok  = req[owner] && s_ack;
                fin_tmo = TMO_EN && req[owner] && !s_ack && (bcnt + 1 == int'(TMO));
                if (fin_ok || fin_tmo) e_ack[owner] = 1'b1;
                if (fin_ok) e_rdata = s_rdata;
                e_err = fin_tmo;
            end
            e_hold = (req[1] && !e_ack[1]) || (req[2] && !e_ack[2]);
            checks++;
            if (grant !== e_grant || ack !== e_ack || err !== e_err || hold !== e_hold)
                begin errors++; $display("FAIL rand%0d_ctrl: grant=%b ack=%b err=%b hold=%b required %b/%b/%b/%b",
                    n, grant, ack, err, hold, e_grant, e_ack, e_err, e_hold); end
            checks++;
            if (s_req !== e_sreq || s_we !== e_we || s_addr !== e_addr || s_wdata !== e_wdata || m_rdata !== e_rdata)
                begin errors++; $display("FAIL rand%0d_bus: s_req=%b we=%b addr=%h wdata=%h rdata=%h required %b/%b/%h/%h/%h",
                    n, s_req, s_we, s_addr, s_wdata, m_rdata, e_sreq, e_we, e_addr, e_wdata, e_rdata); end
            @(posedge clk);
            if (owner < 0) begin
                if (req[0])             owner = 0;
                else if (req[pref])     owner = pref;
                else if (req[3 - pref]) owner = 3 - pref;
                bcnt = 0;
            end else if (e_ack[owner]) begin
                if (owner != 0) pref = 3 - owner;
                owner = -1;
            end else if (!req[owner]) begin
                owner = -1;
            end else begin
                bcnt++;
            end
            #1;
            for (int i = 0; i < 3; i++) if (e_ack[i]) req[i] = 1'b0;
        end
        req = '0; s_ack = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_m0_priority();
        test_stall();
        test_timeout();
        test_abort_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
